// File: rtl/pix_stream_src_pkg.sv
// Shared types and default geometry for the padded pixel stream source.
package pix_stream_src_pkg;

    localparam int PIX_N    = 7;
    localparam int KERNEL   = 5;
    localparam int IM_EDGE  = 28;
    localparam int PAD      = (KERNEL - 1) / 2;
    localparam int IMG_EDGE = IM_EDGE + KERNEL - 1;
    localparam int DEPTH_DEF = IM_EDGE * IM_EDGE;
    localparam int AW_DEF   = $clog2(DEPTH_DEF);

    typedef logic [PIX_N:0] pixel_t;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // True when (r,c) of the padded frame falls in the zero border.
    function automatic logic in_border(input int r, input int c, input int pad, input int im);
        return (r < pad) || (r >= pad + im) || (c < pad) || (c >= pad + im);
    endfunction

endpackage

// File: rtl/pix_stream_src_if.sv
// Image load port plus pixel request/valid handshake of the stream source.
interface pix_stream_src_if
    import pix_stream_src_pkg::*;
#(
    parameter int N  = PIX_N,
    parameter int AW = AW_DEF
);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N:0]    wr_data;
    logic          start;
    logic          data_request;
    logic [N:0]    data;
    logic          data_valid;
    logic          busy;
    logic          frame_done;

    modport master (
        input  wr_en, wr_addr, wr_data, start, data_request,
        output data, data_valid, busy, frame_done
    );

    modport slave (
        output wr_en, wr_addr, wr_data, start, data_request,
        input  data, data_valid, busy, frame_done
    );

endinterface

// File: rtl/pix_stream_src_ram.sv
// Image store: one write port, one registered read port; a colliding read sees the old word.
module pix_ram #(
    parameter int N     = 7,
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [N:0]    rd_data
);

    logic [N:0] mem [DEPTH];

    // Addresses past the image are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pix_stream_src.sv
// Streams the stored image as a zero-padded frame in raster order, one pixel per accepted request.
module pix_stream_src
    import pix_stream_src_pkg::*;
#(
    parameter int N      = PIX_N,
    parameter int stride = KERNEL,
    parameter int im     = IM_EDGE
) (
    input  logic           clk,
    input  logic           reset,
    pix_stream_src_if.master bus
);

    localparam int img   = im + stride - 1;
    localparam int PAD   = (stride - 1) / 2;
    localparam int DEPTH = im * im;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(img);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          last_px;
    logic          border;
    logic          pad_q;
    logic          rd_en;
    logic [AW:0]   rel_row;
    logic [AW:0]   rel_col;
    logic [AW:0]   rd_addr_full;
    logic [N:0]    rd_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last_px    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                accept  = bus.data_request;
                last_px = accept && (row == CW'(img - 1)) && (col == CW'(img - 1));
                if (last_px) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Border pixels never touch the RAM; the MSB guard only matters for odd geometries.
    always_comb begin
        border       = in_border(int'(row), int'(col), PAD, im);
        rel_row      = (AW+1)'(row) - (AW+1)'(PAD);
        rel_col      = (AW+1)'(col) - (AW+1)'(PAD);
        rd_addr_full = rel_row * (AW+1)'(im) + rel_col;
        rd_en        = accept && !border && !rd_addr_full[AW];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row            <= '0;
            col            <= '0;
            pad_q          <= 1'b1;
            bus.data_valid <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.data_valid <= accept;
            bus.frame_done <= last_px;
            if (accept) begin
                pad_q <= border;
                if (col == CW'(img - 1)) begin
                    col <= '0;
                    row <= (row == CW'(img - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Both mux inputs only change on an accepted request, so data holds between pixels.
    assign bus.data = pad_q ? '0 : rd_data;
    assign bus.busy = (state == STREAM);

    pix_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_full[AW-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_pix_stream_src.sv
// Scoreboard bench for pix_stream_src: a frame-level reference model queues expected pixels, a negedge monitor checks them.
module tb_pix_stream_src;
    import pix_stream_src_pkg::*;

    localparam int IMG  = 32;
    localparam int IM   = 28;
    localparam int P    = 2;
    localparam int NPIX = IMG * IMG;
    localparam int DEP  = IM * IM;

    typedef struct packed {
        logic [7:0] pix;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pix_stream_src_if #(.N(7), .AW(10)) bus ();

    pix_stream_src dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       exp_q [$];
    exp_t       e;
    logic [7:0] model_ram [DEP];
    logic [7:0] cap [NPIX];
    logic       m_busy = 1'b0;
    int         m_k = 0;
    logic       exp_busy = 1'b0;
    logic       exp_valid = 1'b0;
    logic       rst_at_edge = 1'b0;
    logic [7:0] exp_hold = 8'h00;
    logic [7:0] old0;
    int         fcount = 0;
    int         checks = 0;
    int         errors = 0;

    // Pixel k of the padded frame, straight from the raster/padding rule.
    function automatic logic [7:0] ref_pix(input int k);
        int r;
        int c;
        r = k / IMG;
        c = k % IMG;
        if (r < P || r >= P + IM || c < P || c >= P + IM) return 8'h00;
        return model_ram[(r - P) * IM + (c - P)];
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // One clock: drive inputs, advance the model for this edge, then publish post-edge expectations.
    task automatic cycle(input logic rn, input logic st, input logic rq, input logic we,
                         input int addr, input logic [7:0] wd);
        logic acc;
        exp_t ne;
        acc              = 1'b0;
        reset            = rn;
        bus.start        = st;
        bus.data_request = rq;
        bus.wr_en        = we;
        bus.wr_addr      = 10'(addr);
        bus.wr_data      = wd;
        if (!rn) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (m_busy) begin
            acc = rq;
            if (acc) begin
                ne.pix = ref_pix(m_k);
                ne.fd  = (m_k == NPIX - 1);
                exp_q.push_back(ne);
                m_k++;
                if (m_k == NPIX) m_busy = 1'b0;
            end
        end else if (st) begin
            m_busy = 1'b1;
            m_k    = 0;
        end
        if (we && addr < DEP) model_ram[addr] = wd;
        @(posedge clk);
        exp_busy  = m_busy;
        exp_valid = acc;
        #1;
    endtask

    // mode 0: continuous, 1: toggled, 2: random requests/writes/starts.
    task automatic run_frame(input int mode, input int abort_at, input int collide_at);
        int guard;
        int addr;
        logic rq;
        logic stt;
        logic we;
        logic [7:0] wd;
        guard = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00);
        while (m_busy && guard < 6000) begin
            we   = 1'b0;
            addr = 0;
            wd   = 8'h00;
            case (mode)
                0:       rq = 1'b1;
                1:       rq = (guard % 2) == 1;
                default: rq = $urandom_range(0, 9) < 7;
            endcase
            stt = (mode == 0) ? (m_k == NPIX - 1) : ($urandom_range(0, 19) == 0);
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                we   = 1'b1;
                addr = $urandom_range(0, 1023);
                wd   = 8'($urandom);
            end
            if (rq && m_k == collide_at) begin
                we   = 1'b1;
                addr = 0;
                wd   = 8'hAA;
            end
            cycle(1'b1, stt, rq, we, addr, wd);
            guard++;
            if (abort_at >= 0 && m_k > abort_at) begin
                cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00);
                break;
            end
        end
        chk("frame_timeout", int'(m_busy), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    always @(posedge clk) rst_at_edge <= reset;

    // Monitor: pops expected pixels whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            chk("rst_valid", int'(bus.data_valid), 0);
            chk("rst_data", int'(bus.data), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_done", int'(bus.frame_done), 0);
            exp_hold = 8'h00;
            fcount   = 0;
        end else begin
            chk("busy", int'(bus.busy), int'(exp_busy));
            chk("valid", int'(bus.data_valid), int'(exp_valid));
            if (bus.data_valid) begin
                chk("queue_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pixel", int'(bus.data), int'(e.pix));
                    chk("frame_done", int'(bus.frame_done), int'(e.fd));
                    exp_hold = e.pix;
                end
                if (fcount < NPIX) cap[fcount] = bus.data;
                fcount++;
                if (bus.frame_done) begin
                    chk("frame_len", fcount, NPIX);
                    fcount = 0;
                end
            end else begin
                chk("hold", int'(bus.data), int'(exp_hold));
                chk("done_no_valid", int'(bus.frame_done), 0);
            end
        end
    end

    initial begin
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.start        = 1'b0;
        bus.data_request = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        // Load RAM[i]=i with stray requests while idle.
        for (int i = 0; i < DEP; i++) begin
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, i, 8'(i));
        end

        run_frame(0, -1, -1);
        chk("pix0", int'(cap[0]), 0);
        chk("pix65", int'(cap[65]), 0);
        chk("pix66", int'(cap[66]), 8'h00);
        chk("pix67", int'(cap[67]), 8'h01);
        chk("pix_2_29", int'(cap[2 * IMG + 29]), 8'h1B);

        run_frame(1, -1, -1);
        chk("throttle_pix67", int'(cap[67]), 8'h01);

        run_frame(2, -1, -1);

        run_frame(0, 300, -1);
        run_frame(0, -1, -1);
        chk("restart_first", int'(cap[0]), 0);

        old0 = model_ram[0];
        run_frame(0, -1, 66);
        chk("collide_old", int'(cap[66]), int'(old0));
        run_frame(0, -1, -1);
        chk("collide_new", int'(cap[66]), 8'hAA);

        cycle(1'b1, 1'b0, 1'b0, 1'b1, 784, 8'h55);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1023, 8'h66);
        run_frame(0, -1, -1);
        chk("oor_pix66", int'(cap[66]), 8'hAA);
        chk("oor_last", int'(cap[29 * IMG + 29]), int'(model_ram[DEP - 1]));

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
